// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST signature engine: FSM states,
// LFSR/MISR feedback tap masks and the default LFSR seed.
package bist_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } bist_state_e;

   // x^8+x^6+x^5+x^4+1, shift-left Fibonacci: taps on bits 7,5,4,3.
   localparam logic [7:0] LFSR_TAP_MASK = 8'hB8;

   // x^10+x^3+1: feedback taken from bits 9 and 2.
   localparam logic [9:0] MISR_TAP_MASK = 10'h204;

   localparam logic [7:0] DEFAULT_SEED = 8'h01;

endpackage : bist_pkg

// File: rtl/bist_signature_engine_if.sv
// Tester-facing handshake and fault-control bundle of the BIST signature engine.
interface bist_signature_engine_if #(
   parameter int SIG_W = 10
);

   logic             valid;
   logic             fault_en;
   logic [2:0]       fault_bit;
   logic             fault_val;
   logic [SIG_W-1:0] Result;
   logic             Ready;

   // Tester side: requests a run, controls fault injection, observes the signature.
   modport master (
      output valid, fault_en, fault_bit, fault_val,
      input  Result, Ready
   );

   // Engine side.
   modport slave (
      input  valid, fault_en, fault_bit, fault_val,
      output Result, Ready
   );

endinterface : bist_signature_engine_if

// File: rtl/bist_signature_engine_cut_adder.sv
// Circuit under test: DATA_W-bit ripple-carry adder (no carry-in, carry kept)
// followed by a stuck-at fault-injection mux on the sum output.
module cut_adder #(
   parameter int DATA_W = 4
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              fault_en,
   input  logic [2:0]        fault_bit,
   input  logic              fault_val,
   output logic [DATA_W:0]   sum
);

   logic [DATA_W:0] carry;
   logic [DATA_W:0] raw_sum;

   assign carry[0] = 1'b0;

   // Ripple chain of full adders; the final carry becomes the sum MSB.
   for (genvar i = 0; i < DATA_W; i++) begin : g_fa
      assign raw_sum[i]  = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1]  = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
   end
   assign raw_sum[DATA_W] = carry[DATA_W];

   // Override one sum bit with the stuck-at value; out-of-range indices leave the sum intact.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      sum = raw_sum;
      if (fault_en && (int'(fault_bit) <= DATA_W)) begin
         sum[fault_bit] = fault_val;
      end
   end

endmodule : cut_adder

// File: rtl/bist_signature_engine.sv
// BIST signature engine: on a tester request, loads an LFSR, feeds PATTERNS
// operand pairs through the adder CUT, compacts each sum into a MISR and
// reports completion on Ready while Result carries the running signature.
module bist_signature_engine
   import bist_pkg::*;
#(
   parameter int                    DATA_W   = 4,
   parameter int                    SIG_W    = 10,
   parameter int                    PATTERNS = 255,
   parameter logic [2*DATA_W-1:0]   SEED     = DEFAULT_SEED
) (
   input  logic                      clk,
   input  logic                      rst,
   bist_signature_engine_if.slave    bus
);

   localparam int LFSR_W = 2 * DATA_W;
   localparam int CNT_W  = $clog2(PATTERNS + 1);

   bist_state_e       state_q, state_d;
   logic [LFSR_W-1:0] lfsr_q,  lfsr_d;
   logic [SIG_W-1:0]  misr_q,  misr_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;

   logic [DATA_W:0]   cut_sum;
   logic              lfsr_fb;
   logic              misr_fb;

   // Operands come straight from the LFSR halves: A = upper, B = lower.
   cut_adder #(
      .DATA_W (DATA_W)
   ) u_cut (
      .a         (lfsr_q[LFSR_W-1:DATA_W]),
      .b         (lfsr_q[DATA_W-1:0]),
      .fault_en  (bus.fault_en),
      .fault_bit (bus.fault_bit),
      .fault_val (bus.fault_val),
      .sum       (cut_sum)
   );

   assign lfsr_fb = ^(lfsr_q & LFSR_W'(LFSR_TAP_MASK));
   assign misr_fb = ^(misr_q & SIG_W'(MISR_TAP_MASK));

   // Next-state logic: FSM sequencing plus LFSR/MISR/counter updates, which only move in RUN.
   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      misr_d  = misr_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (bus.valid) state_d = LOAD;
         end
         LOAD: begin
            if (!bus.valid) begin
               state_d = IDLE;
            end else begin
               lfsr_d  = SEED;
               misr_d  = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (!bus.valid) begin
               // Abort keeps the partial signature visible on Result.
               state_d = IDLE;
            end else begin
               misr_d = {misr_q[SIG_W-2:0], misr_fb} ^ SIG_W'(cut_sum);
               lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_fb};
               cnt_d  = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(PATTERNS - 1)) state_d = DONE;
            end
         end
         DONE: begin
            // Held until the tester releases valid; no automatic restart.
            if (!bus.valid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset taking priority over everything.
   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         lfsr_q  <= SEED;
         misr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         misr_q  <= misr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.Result = misr_q;
   assign bus.Ready  = (state_q == DONE);

endmodule : bist_signature_engine
